// File: rtl/lane_assist_ctrl.sv
// Lane-keeping controller: debounced edge sensors drive a ramped, saturating
// steering correction with timeout alert and conflicting-sensor fault.
module lane_assist_deb #(
  parameter int DEBOUNCE = 3
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic filt
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

module lane_assist_ctrl #(
  parameter int STEER_W   = 4,
  parameter int MAX_STEER = 12,
  parameter int RAMP_STEP = 2,
  parameter int DEBOUNCE  = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               assist_right,
  input  logic               assist_left,
  input  logic               assist_disable,
  output logic [2:0]         lane,
  output logic               steer_dir,
  output logic [STEER_W-1:0] steer_mag,
  output logic               alert,
  output logic               fault
);
  localparam int NUM_SNS = 2;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam logic [STEER_W-1:0] STEP_M =
    STEER_W'((RAMP_STEP > MAX_STEER) ? MAX_STEER : RAMP_STEP);

  typedef enum logic [2:0] {
    CENTER, CORR_R, CORR_L, RELEASE, DISABLED, FAULT
  } state_t;

  // index 0 = right, 1 = left
  logic [NUM_SNS-1:0] raw, filt;
  logic               fr, fl;
  assign raw = {assist_left, assist_right};
  assign fr  = filt[0];
  assign fl  = filt[1];

  genvar g;
  generate
    for (g = 0; g < NUM_SNS; g++) begin : g_deb
      lane_assist_deb #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .CLK  (CLK),
        .RST_N(RST_N),
        .raw  (raw[g]),
        .filt (filt[g])
      );
    end
  endgenerate

  state_t             state, nxt;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic [2:0]         lane_n;
  logic               dir_n, alert_n, fault_n;
  logic [STEER_W-1:0] mag_n, mag_up, mag_dn;
  logic [STEER_W:0]   sum;
  logic               same, opp, clr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= CENTER;
      lane      <= 3'b010;
      steer_dir <= 1'b0;
      steer_mag <= '0;
      alert     <= 1'b0;
      fault     <= 1'b0;
      tcnt      <= '0;
    end else begin
      state     <= nxt;
      lane      <= lane_n;
      steer_dir <= dir_n;
      steer_mag <= mag_n;
      alert     <= alert_n;
      fault     <= fault_n;
      tcnt      <= tcnt_n;
    end
  end

  always_comb begin
    nxt   = state;
    dir_n = steer_dir;
    mag_n = steer_mag;
    // Sum one bit wider so a near-full magnitude clamps instead of wrapping.
    sum    = {1'b0, steer_mag} + (STEER_W+1)'(RAMP_STEP);
    mag_up = (sum > (STEER_W+1)'(MAX_STEER)) ? STEER_W'(MAX_STEER) : sum[STEER_W-1:0];
    mag_dn = (steer_mag > STEER_W'(RAMP_STEP)) ? steer_mag - STEER_W'(RAMP_STEP) : '0;
    same   = steer_dir ? fl : fr;
    opp    = steer_dir ? fr : fl;

    if (assist_disable) begin
      nxt   = DISABLED;
      mag_n = '0;
    end else if (fr && fl) begin
      nxt   = FAULT;
      mag_n = '0;
    end else begin
      case (state)
        CENTER: begin
          if (fr) begin
            nxt = CORR_R; dir_n = 1'b0; mag_n = STEP_M;
          end else if (fl) begin
            nxt = CORR_L; dir_n = 1'b1; mag_n = STEP_M;
          end
        end
        CORR_R: begin
          if (fr) mag_n = mag_up;
          else begin nxt = RELEASE; mag_n = mag_dn; end
        end
        CORR_L: begin
          if (fl) mag_n = mag_up;
          else begin nxt = RELEASE; mag_n = mag_dn; end
        end
        RELEASE: begin
          // Direction only flips once the magnitude has bled off to zero.
          if (same) begin
            nxt   = steer_dir ? CORR_L : CORR_R;
            mag_n = mag_up;
          end else if (steer_mag == '0) begin
            if (opp) begin
              nxt   = steer_dir ? CORR_R : CORR_L;
              dir_n = ~steer_dir;
              mag_n = STEP_M;
            end else begin
              nxt = CENTER;
            end
          end else begin
            mag_n = mag_dn;
          end
        end
        DISABLED: begin
          nxt   = CENTER;
          mag_n = '0;
        end
        FAULT: begin
          mag_n = '0;
          if (!fr && !fl) nxt = CENTER;
        end
        default: begin
          nxt   = CENTER;
          mag_n = '0;
        end
      endcase
    end

    case (nxt)
      CORR_R:   lane_n = 3'b001;
      CORR_L:   lane_n = 3'b100;
      DISABLED: lane_n = 3'b000;
      FAULT:    lane_n = 3'b111;
      default:  lane_n = 3'b010;
    endcase
    fault_n = (nxt == FAULT);

    // Timeout counts cycles spent correcting; RELEASE only pauses it.
    clr = (nxt == CENTER) || (nxt == DISABLED) || (nxt == FAULT);
    if (clr)
      tcnt_n = '0;
    else if ((state == CORR_R || state == CORR_L) && tcnt != TW'(TIMEOUT))
      tcnt_n = tcnt + 1'b1;
    else
      tcnt_n = tcnt;
    alert_n = clr ? 1'b0 : (alert || (tcnt_n == TW'(TIMEOUT)));
  end
endmodule
